// File: rtl/sseg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package sseg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    localparam logic [7:0]  SEG_BLANK  = 8'h00;
    localparam int unsigned SEG_DP_BIT = 7;
    localparam int unsigned MAX_DIGITS = 32;

    // All anodes off; callers slice the low DIGITS bits.
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Load port of the scan controller: packed hex value plus decimal points, valid/ready.
interface sseg_scan_ctrl_if #(
    parameter int unsigned DIGITS = 4
) ();
    logic [4*DIGITS-1:0] Value;
    logic [DIGITS-1:0]   DPMask;
    logic                LoadValid;
    logic                LoadReady;

    modport master (output Value, output DPMask, output LoadValid, input LoadReady);
    modport slave  (input Value, input DPMask, input LoadValid, output LoadReady);
endinterface

// File: rtl/sseg_scan_ctrl_hexadigit.sv
// Hex nibble to active-high 7-segment pattern, SSeg[6:0]=GFEDCBA, SSeg[7]=DP.
module hexaDigit (
    input  logic [3:0] Hex,
    input  logic       DP,
    output logic [7:0] SSeg
);
    logic [6:0] seg;

    always_comb begin
        seg = 7'h00;
        case (Hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    assign SSeg = {DP, seg};
endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan of DIGITS hex digits through one shared decoder.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DWELL     = 50000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Enable,
    sseg_scan_ctrl_if.slave   Load,
    output logic [7:0]        SSeg,
    output logic [DIGITS-1:0] AnodeN,
    output logic              FrameDone
);
    localparam int unsigned CNT_MAX = max3(DWELL, BLANK_CYC, DIGITS);
    localparam int unsigned CW      = $clog2(CNT_MAX);
    localparam int unsigned IW      = $clog2(DIGITS);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam state_e        GAP_ST     = (BLANK_CYC == 0) ? SHOW : BLANK;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                pend_full_q, pend_full_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                fd_q, fd_d;

    logic                xfer;
    logic                wrap;
    logic                frame_edge;
    logic [3:0]          nib;
    logic [7:0]          hex_seg;
    logic                lz_blank;

    assign Load.LoadReady = ~pend_full_q;
    assign SSeg           = seg_q;
    assign AnodeN         = an_q;
    assign FrameDone      = fd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!Enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = GAP_ST;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = GAP_ST;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Display only changes on a frame edge (leaving IDLE or wrapping to digit 0),
    // so a frame never mixes old and new digits.
    always_comb begin
        xfer        = Load.LoadValid && !pend_full_q;
        wrap        = (state_q == SHOW) && (cnt_q == DWELL_LAST) && (idx_q == IDX_LAST);
        frame_edge  = Enable && ((state_q == IDLE) || wrap);
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        if ((state_q == IDLE) && !Enable) begin
            if (xfer) begin
                disp_val_d = Load.Value;
                disp_dp_d  = Load.DPMask;
            end
        end else if (frame_edge) begin
            if (pend_full_q) begin
                disp_val_d  = pend_val_q;
                disp_dp_d   = pend_dp_q;
                pend_full_d = 1'b0;
            end else if (xfer) begin
                disp_val_d = Load.Value;
                disp_dp_d  = Load.DPMask;
            end
        end else if (xfer) begin
            pend_val_d  = Load.Value;
            pend_dp_d   = Load.DPMask;
            pend_full_d = 1'b1;
        end
    end

    hexaDigit u_hex (
        .Hex  (nib),
        .DP   (1'b0),
        .SSeg (hex_seg)
    );

    // Outputs are decoded from next-state values so they register on the entry edge.
    always_comb begin
        nib = disp_val_d[4*idx_d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        lz_blank = (idx_d != '0) && ((disp_val_d >> (4*idx_d)) == '0)
                   && ((disp_dp_d >> idx_d) == '0);
`else
        lz_blank = 1'b0;
`endif
        seg_d = SEG_BLANK;
        an_d  = ANODE_OFF[DIGITS-1:0];
        fd_d  = 1'b0;
        if (state_d == SHOW) begin
            an_d = ~(DIGITS'(1) << idx_d);
            fd_d = (idx_d == IDX_LAST) && (cnt_d == DWELL_LAST);
            if (!lz_blank) begin
                seg_d             = hex_seg;
                seg_d[SEG_DP_BIT] = hex_seg[SEG_DP_BIT] | disp_dp_d[idx_d];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            disp_val_q  <= '0;
            disp_dp_q   <= '0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= ANODE_OFF[DIGITS-1:0];
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_val_q  <= disp_val_d;
            disp_dp_q   <= disp_dp_d;
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed scoreboard bench for sseg_scan_ctrl with DIGITS=4, DWELL=4, BLANK_CYC=1.
module tb_sseg_scan_ctrl;
    localparam int unsigned DIGITS    = 4;
    localparam int unsigned DWELL     = 4;
    localparam int unsigned BLANK_CYC = 1;

    logic       Clk   = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Enable = 1'b0;
    logic [7:0] SSeg;
    logic [3:0] AnodeN;
    logic       FrameDone;

    sseg_scan_ctrl_if #(.DIGITS(DIGITS)) load_if ();

    sseg_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK_CYC(BLANK_CYC)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Enable    (Enable),
        .Load      (load_if.slave),
        .SSeg      (SSeg),
        .AnodeN    (AnodeN),
        .FrameDone (FrameDone)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } slot_t;

    slot_t       exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    logic [7:0]  seg7 [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    function automatic logic [7:0] model_seg(input logic [15:0] v, input logic [3:0] dp,
                                             input int unsigned d);
        logic [7:0] s;
`ifdef LEADING_ZERO_BLANK_EN
        logic [15:0] hi_v;
        logic [3:0]  hi_dp;
`endif
        s = seg7[v[4*d +: 4]];
        if (dp[d]) s[7] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        hi_v  = v >> (4*d);
        hi_dp = dp >> d;
        if (d != 0 && hi_v == 16'h0 && hi_dp == 4'h0) s = 8'h00;
`endif
        return s;
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] dp);
        slot_t s;
        for (int d = 0; d < int'(DIGITS); d++) begin
            s.an  = 4'(~(4'b0001 << d));
            s.seg = model_seg(v, dp, d);
            exp_q.push_back(s);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pop_slot(output slot_t e);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL sb_underflow: observed=0 entries expected=1");
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic blank_cyc();
        tick();
        chk("blank_an", 16'(AnodeN), 16'hF);
        chk("blank_seg", 16'(SSeg), 16'h00);
        chk("blank_fd", 16'(FrameDone), 16'h0);
    endtask

    task automatic show_cyc(input slot_t e, input bit last);
        tick();
        chk("show_an", 16'(AnodeN), 16'(e.an));
        chk("show_seg", 16'(SSeg), 16'(e.seg));
        chk("show_fd", 16'(FrameDone), 16'(last));
    endtask

    task automatic digit(input bit last);
        slot_t e;
        pop_slot(e);
        blank_cyc();
        for (int c = 0; c < int'(DWELL); c++) show_cyc(e, last && (c == int'(DWELL) - 1));
    endtask

    task automatic frame();
        for (int d = 0; d < int'(DIGITS); d++) digit(d == int'(DIGITS) - 1);
    endtask

    initial begin
        slot_t e;
        load_if.Value     = '0;
        load_if.DPMask    = '0;
        load_if.LoadValid = 1'b0;

        // reset held three cycles, then idle
        repeat (3) begin
            tick();
            chk("rst_an", 16'(AnodeN), 16'hF);
            chk("rst_seg", 16'(SSeg), 16'h00);
            chk("rst_rdy", 16'(load_if.LoadReady), 16'h1);
            chk("rst_fd", 16'(FrameDone), 16'h0);
        end
        Rst_n = 1'b1;
        repeat (2) begin
            tick();
            chk("idle_an", 16'(AnodeN), 16'hF);
            chk("idle_fd", 16'(FrameDone), 16'h0);
        end

        // load in IDLE goes straight to display
        load_if.Value = 16'h12AF; load_if.DPMask = 4'b0100; load_if.LoadValid = 1'b1;
        tick();
        load_if.LoadValid = 1'b0;
        chk("idle_load_rdy", 16'(load_if.LoadReady), 16'h1);
        chk("idle_load_an", 16'(AnodeN), 16'hF);

        Enable = 1'b1;
        push_frame(16'h12AF, 4'b0100);
        frame();

        // mid-frame load during digit 1, second offer while full is ignored
        push_frame(16'h12AF, 4'b0100);
        digit(1'b0);
        pop_slot(e);
        blank_cyc();
        show_cyc(e, 1'b0);
        load_if.Value = 16'h0003; load_if.DPMask = 4'b0000; load_if.LoadValid = 1'b1;
        show_cyc(e, 1'b0);
        chk("mid_rdy_low", 16'(load_if.LoadReady), 16'h0);
        load_if.Value = 16'hFFFF; load_if.DPMask = 4'b1111;
        show_cyc(e, 1'b0);
        chk("full_rdy_low", 16'(load_if.LoadReady), 16'h0);
        load_if.LoadValid = 1'b0;
        show_cyc(e, 1'b0);
        digit(1'b0);
        digit(1'b1);
        chk("rdy_before_edge", 16'(load_if.LoadReady), 16'h0);

        // pending drains at the frame edge
        push_frame(16'h0003, 4'b0000);
        pop_slot(e);
        blank_cyc();
        chk("rdy_after_drain", 16'(load_if.LoadReady), 16'h1);
        for (int c = 0; c < int'(DWELL); c++) show_cyc(e, 1'b0);
        digit(1'b0);
        digit(1'b0);
        digit(1'b1);

        // transfer on the last cycle of digit 3 bypasses to display
        load_if.Value = 16'h0040; load_if.DPMask = 4'b0000; load_if.LoadValid = 1'b1;
        push_frame(16'h0040, 4'b0000);
        pop_slot(e);
        blank_cyc();
        load_if.LoadValid = 1'b0;
        chk("bypass_rdy", 16'(load_if.LoadReady), 16'h1);
        for (int c = 0; c < int'(DWELL); c++) show_cyc(e, 1'b0);
        pop_slot(e);
        blank_cyc();
        show_cyc(e, 1'b0);
        load_if.DPMask = 4'b1000; load_if.LoadValid = 1'b1;
        show_cyc(e, 1'b0);
        load_if.LoadValid = 1'b0;
        chk("mid2_rdy_low", 16'(load_if.LoadReady), 16'h0);
        show_cyc(e, 1'b0);
        show_cyc(e, 1'b0);
        digit(1'b0);
        digit(1'b1);

        push_frame(16'h0040, 4'b1000);
        frame();

        // disable during digit 2, then restart from digit 0
        push_frame(16'h0040, 4'b1000);
        digit(1'b0);
        digit(1'b0);
        pop_slot(e);
        blank_cyc();
        show_cyc(e, 1'b0);
        show_cyc(e, 1'b0);
        Enable = 1'b0;
        tick();
        chk("dis_an", 16'(AnodeN), 16'hF);
        chk("dis_seg", 16'(SSeg), 16'h00);
        chk("dis_fd", 16'(FrameDone), 16'h0);
        void'(exp_q.pop_front());
        tick();
        chk("dis_idle_an", 16'(AnodeN), 16'hF);
        Enable = 1'b1;
        push_frame(16'h0040, 4'b1000);
        frame();

        // reset mid-SHOW with a pending value outstanding
        push_frame(16'h0040, 4'b1000);
        digit(1'b0);
        pop_slot(e);
        blank_cyc();
        show_cyc(e, 1'b0);
        load_if.Value = 16'h1234; load_if.DPMask = 4'b0001; load_if.LoadValid = 1'b1;
        show_cyc(e, 1'b0);
        load_if.LoadValid = 1'b0;
        chk("pre_rst_rdy", 16'(load_if.LoadReady), 16'h0);
        Rst_n = 1'b0;
        tick();
        chk("mid_rst_an", 16'(AnodeN), 16'hF);
        chk("mid_rst_seg", 16'(SSeg), 16'h00);
        chk("mid_rst_rdy", 16'(load_if.LoadReady), 16'h1);
        chk("mid_rst_fd", 16'(FrameDone), 16'h0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        Rst_n = 1'b1;
        push_frame(16'h0000, 4'b0000);
        frame();

        chk("sb_empty", 16'(exp_q.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
